// File: rtl/n_clic_sched.sv
// Edge-triggered interrupt scheduler: pending/enable/priority per vector, max-priority
// arbitration above the current nesting level, offered to the core over take_req/take_ack.
// Optional macro N_CLIC_SCHED_PREEMPT_EN lets a strictly higher-priority vector replace a live offer.
module n_clic_sched #(
    parameter int                   VecSize   = 8,
    parameter int                   PrioWidth = 3,
    parameter int                   AddrWidth = 12,
    parameter logic [AddrWidth-1:0] VecBase   = 'h100
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [VecSize-1:0]         irq_in,
    input  logic                       cfg_we,
    input  logic [$clog2(VecSize)-1:0] cfg_idx,
    input  logic                       cfg_en,
    input  logic [PrioWidth-1:0]       cfg_prio,
    input  logic [PrioWidth-1:0]       cur_level,
    input  logic                       take_ack,
    output logic                       take_req,
    output logic [$clog2(VecSize)-1:0] take_idx,
    output logic [AddrWidth-1:0]       take_addr,
    output logic [PrioWidth-1:0]       take_level,
    output logic [VecSize-1:0]         pending_out
);

    localparam int IdxW = $clog2(VecSize);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [VecSize-1:0]     irq_hist_q, irq_hist_d;
    logic [VecSize-1:0]     pending_q, pending_d;
    logic [VecSize-1:0]     en_q, en_d;
    logic [PrioWidth-1:0]   prio_q [VecSize];
    logic [PrioWidth-1:0]   prio_d [VecSize];
    logic                   take_req_q, take_req_d;
    logic [IdxW-1:0]        take_idx_q, take_idx_d;
    logic [AddrWidth-1:0]   take_addr_q, take_addr_d;
    logic [PrioWidth-1:0]   take_level_q, take_level_d;

    logic [VecSize-1:0]     elig;
    logic                   win_found;
    logic [IdxW-1:0]        win_idx;
    logic [PrioWidth-1:0]   win_prio;
    logic                   take_fire;
    logic [VecSize-1:0]     clr_mask;

    // Handshake: an offer is transferred on a cycle with take_req && take_ack; while
    // take_req is high take_* hold their value unless the offer is withdrawn or replaced.
    assign take_fire = take_req_q & take_ack;

    always_comb begin
        elig      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        win_prio  = '0;
        for (int i = 0; i < VecSize; i++) begin
            elig[i] = pending_q[i] & en_q[i] & (prio_q[i] > cur_level);
        end
        // Strict '>' keeps the lowest index on equal priority.
        for (int i = 0; i < VecSize; i++) begin
            if (elig[i] && (!win_found || prio_q[i] > win_prio)) begin
                win_found = 1'b1;
                win_idx   = IdxW'(i);
                win_prio  = prio_q[i];
            end
        end
    end

    always_comb begin
        irq_hist_d = irq_in;
        clr_mask   = '0;
        en_d       = en_q;
        prio_d     = prio_q;
        for (int i = 0; i < VecSize; i++) begin
            if (take_fire && take_idx_q == IdxW'(i)) begin
                clr_mask[i] = 1'b1;
            end
            if (cfg_we && cfg_idx == IdxW'(i)) begin
                en_d[i]   = cfg_en;
                prio_d[i] = cfg_prio;
            end
        end
        // A new edge on the same cycle as the ack must not be lost.
        pending_d = (pending_q & ~clr_mask) | (irq_in & ~irq_hist_q);
    end

    always_comb begin
        state_d      = state_q;
        take_req_d   = take_req_q;
        take_idx_d   = take_idx_q;
        take_addr_d  = take_addr_q;
        take_level_d = take_level_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d      = ST_REQ;
                    take_req_d   = 1'b1;
                    take_idx_d   = win_idx;
                    take_level_d = win_prio;
                    take_addr_d  = VecBase + (AddrWidth'(win_idx) << 2);
                end
            end
            ST_REQ: begin
                if (take_ack) begin
                    state_d    = ST_WAIT;
                    take_req_d = 1'b0;
                end else if (!elig[take_idx_q]) begin
                    state_d    = ST_IDLE;
                    take_req_d = 1'b0;
                end
`ifdef N_CLIC_SCHED_PREEMPT_EN
                else if (win_found && win_prio > take_level_q) begin
                    take_idx_d   = win_idx;
                    take_level_d = win_prio;
                    take_addr_d  = VecBase + (AddrWidth'(win_idx) << 2);
                end
`endif
            end
            ST_WAIT: begin
                // One quiet cycle lets the core push the new level into cur_level.
                state_d    = ST_IDLE;
                take_req_d = 1'b0;
            end
            default: begin
                state_d    = ST_IDLE;
                take_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            irq_hist_q   <= '0;
            pending_q    <= '0;
            en_q         <= '0;
            prio_q       <= '{default: '0};
            take_req_q   <= 1'b0;
            take_idx_q   <= '0;
            take_addr_q  <= '0;
            take_level_q <= '0;
        end else begin
            state_q      <= state_d;
            irq_hist_q   <= irq_hist_d;
            pending_q    <= pending_d;
            en_q         <= en_d;
            prio_q       <= prio_d;
            take_req_q   <= take_req_d;
            take_idx_q   <= take_idx_d;
            take_addr_q  <= take_addr_d;
            take_level_q <= take_level_d;
        end
    end

    assign take_req    = take_req_q;
    assign take_idx    = take_idx_q;
    assign take_addr   = take_addr_q;
    assign take_level  = take_level_q;
    assign pending_out = pending_q;

endmodule

// File: tb/tb_n_clic_sched.sv
// Directed bench for n_clic_sched (default 8 vectors, 3-bit priority, VecBase 'h100).
module tb_n_clic_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic       cfg_en;
    logic [2:0] cfg_prio;
    logic [2:0] cur_level;
    logic       take_ack;
    logic       take_req;
    logic [2:0] take_idx;
    logic [11:0] take_addr;
    logic [2:0] take_level;
    logic [7:0] pending_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    n_clic_sched dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_en(cfg_en), .cfg_prio(cfg_prio), .cur_level(cur_level), .take_ack(take_ack),
        .take_req(take_req), .take_idx(take_idx), .take_addr(take_addr),
        .take_level(take_level), .pending_out(pending_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; irq_in = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
        cfg_prio = '0; cur_level = '0; take_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic cfg(input logic [2:0] idx, input logic en, input logic [2:0] prio);
        cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_prio = prio;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] lines);
        irq_in = lines;
        tick();
        irq_in = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; irq_in = 8'h80; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
        cfg_prio = '0; cur_level = '0; take_ack = 1'b0;
        tick(); tick();
        n_checks++; if (take_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", take_req); end
        n_checks++; if ({take_idx, take_addr, take_level} !== 18'd0) begin n_fail++; $display("FAIL reset_take got %h/%h/%h exp 0", take_idx, take_addr, take_level); end
        n_checks++; if (pending_out !== 8'h00) begin n_fail++; $display("FAIL reset_pending got %h exp 00", pending_out); end
        // A line already high when reset drops counts as an edge.
        reset = 1'b0;
        tick();
        n_checks++; if (pending_out !== 8'h80) begin n_fail++; $display("FAIL reset_release_edge got %h exp 80", pending_out); end
        irq_in = '0;
    endtask

    task automatic test_basic();
        do_reset();
        cfg(3'd3, 1'b1, 3'd2);
        pulse(8'h08);
        n_checks++; if (pending_out !== 8'h08 || take_req !== 1'b0) begin n_fail++; $display("FAIL basic_pend got %h/%b exp 08/0", pending_out, take_req); end
        tick();
        n_checks++; if (take_req !== 1'b1 || take_idx !== 3'd3) begin n_fail++; $display("FAIL basic_offer got %b/%0d exp 1/3", take_req, take_idx); end
        n_checks++; if (take_addr !== 12'h10C || take_level !== 3'd2) begin n_fail++; $display("FAIL basic_addr got %h/%0d exp 10c/2", take_addr, take_level); end
        take_ack = 1'b1;
        tick();
        take_ack = 1'b0;
        n_checks++; if (take_req !== 1'b0 || pending_out !== 8'h00) begin n_fail++; $display("FAIL basic_ack got %b/%h exp 0/00", take_req, pending_out); end
        tick();
        n_checks++; if (take_req !== 1'b0) begin n_fail++; $display("FAIL basic_wait got %b exp 0", take_req); end
        tick();
        n_checks++; if (take_req !== 1'b0) begin n_fail++; $display("FAIL basic_idle got %b exp 0", take_req); end
    endtask

    task automatic test_tie();
        do_reset();
        cfg(3'd1, 1'b1, 3'd4);
        cfg(3'd5, 1'b1, 3'd4);
        pulse(8'h22);
        tick();
        n_checks++; if (take_req !== 1'b1 || take_idx !== 3'd1 || take_addr !== 12'h104) begin n_fail++; $display("FAIL tie_first got %b/%0d/%h exp 1/1/104", take_req, take_idx, take_addr); end
        take_ack = 1'b1;
        tick();
        take_ack = 1'b0;
        n_checks++; if (pending_out !== 8'h20 || take_req !== 1'b0) begin n_fail++; $display("FAIL tie_ack got %h/%b exp 20/0", pending_out, take_req); end
        tick();
        n_checks++; if (take_req !== 1'b0) begin n_fail++; $display("FAIL tie_wait got %b exp 0", take_req); end
        tick();
        n_checks++; if (take_req !== 1'b1 || take_idx !== 3'd5 || take_addr !== 12'h114) begin n_fail++; $display("FAIL tie_second got %b/%0d/%h exp 1/5/114", take_req, take_idx, take_addr); end
    endtask

    task automatic test_level();
        do_reset();
        cur_level = 3'd3;
        cfg(3'd2, 1'b1, 3'd3);
        pulse(8'h04);
        tick(); tick();
        n_checks++; if (take_req !== 1'b0 || pending_out !== 8'h04) begin n_fail++; $display("FAIL level_block got %b/%h exp 0/04", take_req, pending_out); end
        cur_level = 3'd2;
        tick();
        n_checks++; if (take_req !== 1'b1 || take_idx !== 3'd2 || take_level !== 3'd3) begin n_fail++; $display("FAIL level_open got %b/%0d/%0d exp 1/2/3", take_req, take_idx, take_level); end
    endtask

    task automatic test_withdraw();
        do_reset();
        cfg(3'd4, 1'b1, 3'd3);
        pulse(8'h10);
        tick();
        n_checks++; if (take_req !== 1'b1 || take_idx !== 3'd4) begin n_fail++; $display("FAIL wd_offer got %b/%0d exp 1/4", take_req, take_idx); end
        cfg(3'd4, 1'b0, 3'd3);
        n_checks++; if (take_req !== 1'b1) begin n_fail++; $display("FAIL wd_hold got %b exp 1", take_req); end
        tick();
        n_checks++; if (take_req !== 1'b0 || pending_out !== 8'h10) begin n_fail++; $display("FAIL wd_drop got %b/%h exp 0/10", take_req, pending_out); end
        // An ack with no offer outstanding must not clear anything.
        take_ack = 1'b1;
        tick();
        take_ack = 1'b0;
        n_checks++; if (pending_out !== 8'h10 || take_req !== 1'b0) begin n_fail++; $display("FAIL wd_stray_ack got %h/%b exp 10/0", pending_out, take_req); end
    endtask

    task automatic test_preempt();
        do_reset();
        cfg(3'd0, 1'b1, 3'd1);
        cfg(3'd6, 1'b1, 3'd5);
        pulse(8'h01);
        tick();
        n_checks++; if (take_req !== 1'b1 || take_idx !== 3'd0 || take_level !== 3'd1) begin n_fail++; $display("FAIL pre_offer got %b/%0d/%0d exp 1/0/1", take_req, take_idx, take_level); end
        pulse(8'h40);
        n_checks++; if (take_idx !== 3'd0 || pending_out !== 8'h41) begin n_fail++; $display("FAIL pre_pend got %0d/%h exp 0/41", take_idx, pending_out); end
        tick();
`ifdef N_CLIC_SCHED_PREEMPT_EN
        n_checks++; if (take_req !== 1'b1 || take_idx !== 3'd6 || take_addr !== 12'h118 || take_level !== 3'd5) begin n_fail++; $display("FAIL pre_swap got %b/%0d/%h/%0d exp 1/6/118/5", take_req, take_idx, take_addr, take_level); end
        take_ack = 1'b1;
        tick();
        take_ack = 1'b0;
        n_checks++; if (pending_out !== 8'h01) begin n_fail++; $display("FAIL pre_ack got %h exp 01", pending_out); end
`else
        n_checks++; if (take_req !== 1'b1 || take_idx !== 3'd0 || take_addr !== 12'h100) begin n_fail++; $display("FAIL pre_fixed got %b/%0d/%h exp 1/0/100", take_req, take_idx, take_addr); end
        take_ack = 1'b1;
        tick();
        take_ack = 1'b0;
        n_checks++; if (pending_out !== 8'h40 || take_req !== 1'b0) begin n_fail++; $display("FAIL pre_ack got %h/%b exp 40/0", pending_out, take_req); end
        tick(); tick();
        n_checks++; if (take_req !== 1'b1 || take_idx !== 3'd6 || take_level !== 3'd5) begin n_fail++; $display("FAIL pre_next got %b/%0d/%0d exp 1/6/5", take_req, take_idx, take_level); end
`endif
    endtask

    task automatic test_back_to_back();
        do_reset();
        cfg(3'd2, 1'b1, 3'd2);
        pulse(8'h04);
        tick();
        n_checks++; if (take_req !== 1'b1 || take_idx !== 3'd2) begin n_fail++; $display("FAIL b2b_offer got %b/%0d exp 1/2", take_req, take_idx); end
        irq_in = 8'h04; take_ack = 1'b1;
        tick();
        irq_in = '0; take_ack = 1'b0;
        n_checks++; if (take_req !== 1'b0 || pending_out !== 8'h04) begin n_fail++; $display("FAIL b2b_setwins got %b/%h exp 0/04", take_req, pending_out); end
        tick(); tick();
        n_checks++; if (take_req !== 1'b1 || take_idx !== 3'd2 || take_addr !== 12'h108) begin n_fail++; $display("FAIL b2b_reoffer got %b/%0d/%h exp 1/2/108", take_req, take_idx, take_addr); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if ({take_req, take_idx, take_addr, take_level, pending_out} !== 27'd0) begin n_fail++; $display("FAIL b2b_reset got %b/%0d/%h/%0d/%h exp all 0", take_req, take_idx, take_addr, take_level, pending_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_level();
        test_withdraw();
        test_preempt();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
